// File: rtl/lector_fifos_azules_pkg.sv
// Shared definitions for the blue-FIFO egress reader: FSM encodings, word field positions, port count.
// No logic, no latency.
// Backpressure: not applicable.
package lector_fifos_azules_pkg;
    localparam int NPORTS    = 4;
    localparam int DEST_MSB  = 9;
    localparam int DEST_LSB  = 8;
    localparam int CLASS_MSB = 11;
    localparam int CLASS_LSB = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/lector_fifos_azules_rr_arbitro_4.sv
// Four-way round-robin arbiter: first requester after rr_ptr wins, searching upward modulo 4.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbitro_4
    import lector_fifos_azules_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [1:0]        rr_ptr,
    output logic [NPORTS-1:0] gnt_oh,
    output logic [1:0]        gnt_enc,
    output logic              grant_valid
);

    logic [1:0] cand;

    always_comb begin
        gnt_enc     = 2'd0;
        grant_valid = 1'b0;
        cand        = 2'd0;
        // Offset 4 wraps to rr_ptr itself, so the last owner is checked last.
        for (int i = 1; i <= NPORTS; i++) begin
            cand = rr_ptr + 2'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                gnt_enc     = cand;
            end
        end
        gnt_oh = grant_valid ? (4'b0001 << gnt_enc) : 4'b0000;
    end

endmodule

// File: rtl/lector_fifos_azules.sv
// Egress reader draining four blue FIFOs round-robin onto a valid/ready port, with per-port counters; LECTOR_DEST_CHECK_EN adds dest check.
// Latency: pop in cycle N -> valid_out in N+2; counter readback one cycle after req.
// Backpressure: out_ready low parks the word in HOLD and suppresses further pops.
module lector_fifos_azules
    import lector_fifos_azules_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Enable,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] data_in_p0,
    input  logic [DATA_W-1:0] data_in_p1,
    input  logic [DATA_W-1:0] data_in_p2,
    input  logic [DATA_W-1:0] data_in_p3,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        port_out,
    output logic              valid_out,
    input  logic              out_ready,
    output logic              dest_mismatch,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  count_data,
    output logic              count_valid,
    output logic              idle
);

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [1:0]        gnt_q;
    logic [CNT_W-1:0]  cnt [NPORTS];
    logic [DATA_W-1:0] data_in [NPORTS];

    logic [NPORTS-1:0] gnt_oh;
    logic [1:0]        gnt_enc;
    logic              grant_valid;
    logic              accept;
    logic              grant_go;

    assign data_in[0] = data_in_p0;
    assign data_in[1] = data_in_p1;
    assign data_in[2] = data_in_p2;
    assign data_in[3] = data_in_p3;

    rr_arbitro_4 u_arb (
        .req         (~fifo_empty),
        .rr_ptr      (rr_ptr),
        .gnt_oh      (gnt_oh),
        .gnt_enc     (gnt_enc),
        .grant_valid (grant_valid)
    );

    assign accept   = (state == ST_HOLD) && out_ready;
    // A new grant is taken from IDLE, or overlapped with the accept of the held word.
    assign grant_go = !reset && Enable && grant_valid && ((state == ST_IDLE) || accept);
    assign pop      = grant_go ? gnt_oh : 4'b0000;
    assign idle     = !reset && (state == ST_IDLE) && (&fifo_empty);

`ifdef LECTOR_DEST_CHECK_EN
    assign dest_mismatch = valid_out && (data_out[DEST_MSB:DEST_LSB] != port_out);
`else
    assign dest_mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= 2'd3;
            gnt_q       <= 2'd0;
            data_out    <= '0;
            port_out    <= 2'd0;
            valid_out   <= 1'b0;
            count_data  <= '0;
            count_valid <= 1'b0;
            for (int i = 0; i < NPORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // Nonblocking read sees the pre-increment value on a same-cycle accept.
            count_valid <= req;
            if (req) begin
                count_data <= cnt[idx];
            end

            if (grant_go) begin
                gnt_q  <= gnt_enc;
                rr_ptr <= gnt_enc;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_go) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    data_out  <= data_in[gnt_q];
                    port_out  <= gnt_q;
                    valid_out <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        cnt[port_out] <= cnt[port_out] + CNT_W'(1);
                        valid_out     <= 1'b0;
                        state         <= grant_go ? ST_WAIT : ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lector_fifos_azules.md
Name: lector_fifos_azules

Overview:
Egress reader for the transaction layer. Drains the four blue output FIFOs (ports p0..p3) through their pop inputs, using round-robin arbitration over the non-empty ports. Presents one word at a time on a valid/ready output interface and checks that the word's dest field matches the port it came from. Keeps per-port delivered-word counters that can be read back with a req/idx interface.

Parameters:
DATA_W, 12, word width; bits [11:10] are class, bits [9:8] are dest.
CNT_W, 5, width of each per-port delivered-word counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
Enable  input  1  permits new pops when high
fifo_empty  input  4  empty flags of blue FIFOs p3..p0
data_in_p0  input  DATA_W  FIFO_data_out of blue FIFO p0
data_in_p1  input  DATA_W  FIFO_data_out of blue FIFO p1
data_in_p2  input  DATA_W  FIFO_data_out of blue FIFO p2
data_in_p3  input  DATA_W  FIFO_data_out of blue FIFO p3
pop  output  4  one-hot read_enable to the blue FIFOs
data_out  output  DATA_W  captured word
port_out  output  2  source port of data_out
valid_out  output  1  data_out/port_out valid
out_ready  input  1  downstream accepts the word when valid_out and out_ready are both high
dest_mismatch  output  1  data_out[9:8] != port_out while valid_out is high
req  input  1  counter read request
idx  input  2  counter to read
count_data  output  CNT_W  counter value
count_valid  output  1  count_data valid
idle  output  1  high in IDLE state when all fifo_empty bits are 1

Behaviour:
- Fixed timing: the blue FIFO read is registered. Data for a pop issued in cycle N is on data_in_pX in cycle N+1.
- Reset values: every output is 0; the round-robin pointer rr_ptr is 3, so the first grant goes to p0; all counters are 0; state is IDLE.
- Grant rule: the grant is the first port with fifo_empty=0, searching rr_ptr+1, rr_ptr+2, … modulo 4. On a grant, rr_ptr takes the granted port.
- pop is combinational. It has at most one bit set and is only asserted on a grant cycle.
- FSM states are IDLE, WAIT and HOLD.
- IDLE:
  - If Enable=1 and any fifo_empty bit is 0: assert pop[grant], latch gnt_q=grant, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - pop=0.
  - Register data_out=data_in[gnt_q] and port_out=gnt_q.
  - Go to HOLD; valid_out=1 from the next cycle.
- HOLD:
  - valid_out=1; data_out and port_out are held stable.
  - If out_ready=1, the word is accepted: counter[port_out] increments, wrapping 2^CNT_W-1 to 0.
  - On accept, if Enable=1 and a non-empty port exists, grant in the same cycle (pop asserted) and go to WAIT.
  - On accept with no grant possible, go to IDLE.
  - If out_ready=0, stay in HOLD with no pop.
- valid_out is low in WAIT and IDLE.
- Latency: pop in cycle N gives valid_out in cycle N+2. Sustained throughput is 1 word per 2 cycles.
- Enable=0 blocks only new grants. A word in WAIT or HOLD completes normally.
- A fifo_empty bit that rises after the grant has no effect; the captured word is still delivered.
- Counter readback:
  - req=1 in cycle N gives count_valid=1 and count_data=counter[idx] in cycle N+1.
  - count_valid is a one-cycle pulse per req cycle.
  - If a read and an increment hit the same counter in the same cycle, the read returns the pre-increment value.
- Reset asserted mid-operation: in the next cycle the state is IDLE, pop=0, all outputs are 0, counters are 0 and rr_ptr=3. An in-flight word is discarded.

Optional Feature:
LECTOR_DEST_CHECK_EN
- Defined: dest_mismatch = valid_out & (data_out[9:8] != port_out). A mismatched word is still delivered and counted.
- Undefined: dest_mismatch is tied to 0 and no compare logic is built.

Decomposition:
- Shared package/include file lector_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_HOLD=2'd2;
  - field positions DEST_MSB=9, DEST_LSB=8, CLASS_MSB=11, CLASS_LSB=10;
  - NPORTS=4.
- One sub-module, rr_arbitro_4: inputs are the request vector (~fifo_empty) and rr_ptr; outputs are the one-hot grant, the encoded grant and grant_valid. It is purely combinational.
- The FSM, capture register and counters stay in the top module.

Test Plan:
1. Single word: after reset, fifo_empty=4'b1101 and data_in_p1=12'h1A5 (dest=1). Required: pop=4'b0010 in cycle 0, valid_out=1 with data_out=12'h1A5, port_out=1 in cycle 2, dest_mismatch=0; out_ready=1 then gives counter[1]=1.
2. Round-robin: all four ports non-empty and out_ready=1 held. Required: pops go p0,p1,p2,p3,p0 on cycles 0,2,4,6,8.
3. Backpressure: out_ready=0 for 5 cycles while in HOLD. Required: valid_out and data_out stable, pop=0 throughout, no count; one cycle of out_ready=1 gives exactly one increment.
4. Dest check (LECTOR_DEST_CHECK_EN defined): word 12'h300 (dest=3) arrives on p2. Required: dest_mismatch=1 for every cycle valid_out=1; counter[2] still increments. With the macro undefined, dest_mismatch stays 0.
5. Counter wrap and readback: 32 accepted words on p3, then req=1 with idx=3. Required: count_valid=1 and count_data=0 one cycle later. A req on a cycle with a concurrent increment returns the old value.
6. Reset and Enable: reset asserted in WAIT gives outputs 0 and IDLE next cycle, and the first post-reset grant is p0. Enable=0 with non-empty FIFOs gives pop=0 and idle=0; dropping Enable in HOLD still lets the held word complete.
